// File: rtl/puf_response_engine_pkg.sv
// Shared types, defaults and helpers for the arbiter-PUF response engine.
package puf_pkg;

    localparam int C_LENGTH_DEF      = 8;
    localparam int N_CHAINS_DEF      = 4;
    localparam int N_VOTES_DEF       = 5;
    localparam int SETTLE_CYCLES_DEF = 4;

    // Mask used only by the behavioural chain model in simulation builds.
    localparam logic [7:0] SIM_MASK = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SETTLE,
        ST_SAMPLE,
        ST_RECOVER,
        ST_DONE
    } state_e;

    function automatic int vote_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/puf_response_engine_if.sv
// Challenge/response handshake bundle between the pin wrapper and the engine.
interface puf_response_engine_if
    import puf_pkg::*;
#(
    parameter int C_LENGTH = C_LENGTH_DEF,
    parameter int N_CHAINS = N_CHAINS_DEF
) ();
    logic                i_valid;
    logic [C_LENGTH-1:0] i_challenge;
    logic                o_ready;
    logic                o_valid;
    logic [N_CHAINS-1:0] o_response;
    logic [N_CHAINS-1:0] o_unstable;
    logic                i_ready;

    modport master (
        output i_valid, i_challenge, i_ready,
        input  o_ready, o_valid, o_response, o_unstable
    );

    modport slave (
        input  i_valid, i_challenge, i_ready,
        output o_ready, o_valid, o_response, o_unstable
    );
endinterface

// File: rtl/puf_response_engine_delay_chain.sv
// One arbiter-PUF delay chain: crossed mux pairs racing into an arbiter flop.
// SYNTHESIS builds the real structure; otherwise a parity model stands in.
module puf_delay_chain
    import puf_pkg::*;
#(
    parameter int C_LENGTH = C_LENGTH_DEF
) (
    input  logic [C_LENGTH-1:0] challenge_i,
    input  logic                pulse_i,
    output logic                arb_o
);
`ifdef SYNTHESIS
    (* dont_touch = "true" *) logic [C_LENGTH:0] top_w;
    (* dont_touch = "true" *) logic [C_LENGTH:0] bot_w;
    (* dont_touch = "true" *) logic              arb_q;

    assign top_w[0] = pulse_i;
    assign bot_w[0] = pulse_i;

    // A set challenge bit swaps the two race paths at that stage.
    for (genvar gi = 0; gi < C_LENGTH; gi++) begin : gen_stage
        assign top_w[gi+1] = challenge_i[gi] ? bot_w[gi] : top_w[gi];
        assign bot_w[gi+1] = challenge_i[gi] ? top_w[gi] : bot_w[gi];
    end

    always_ff @(posedge top_w[C_LENGTH]) begin
        arb_q <= bot_w[C_LENGTH];
    end
`else
    localparam logic [C_LENGTH-1:0] MASK = C_LENGTH'(SIM_MASK);
    logic arb_q;

    always_ff @(posedge pulse_i) begin
        arb_q <= ^(challenge_i & MASK);
    end
`endif
    assign arb_o = arb_q;
endmodule

// File: rtl/puf_response_engine.sv
// Multi-chain arbiter-PUF controller: repeated launches, majority vote per chain.
// Optional PUF_STABILITY_EN flags chains whose votes were not unanimous.
module puf_response_engine
    import puf_pkg::*;
#(
    parameter int C_LENGTH      = C_LENGTH_DEF,
    parameter int N_CHAINS      = N_CHAINS_DEF,
    parameter int N_VOTES       = N_VOTES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    puf_response_engine_if.slave bus
);
    localparam int CW = vote_cnt_w(N_VOTES);
    localparam int SW = vote_cnt_w(SETTLE_CYCLES);
    localparam logic [SW-1:0] TICK_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] VOTE_LAST = CW'(N_VOTES - 1);
    localparam logic [CW-1:0] VOTE_HALF = CW'(N_VOTES / 2);

    state_e              state_q, state_d;
    logic                ready_q, ready_d, valid_q, valid_d;
    logic                pulse_q, pulse_d;
    logic [SW-1:0]       tick_q, tick_d;
    logic [CW-1:0]       vote_q, vote_d;
    logic [C_LENGTH-1:0] chal_q, chal_d;
    logic [N_CHAINS-1:0] resp_q, resp_d, unst_q, unst_d;
    logic [N_CHAINS-1:0] sync1_q, sync2_q, arb_bus_w, maj_w, diff_w;
    logic                tick_done, accept, launch, sample, run_tick;

    assign tick_done = (tick_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                ST_IDLE:    if (bus.i_valid && ready_q) state_d = ST_LAUNCH;
                ST_LAUNCH:  state_d = ST_SETTLE;
                ST_SETTLE:  if (tick_done) state_d = ST_SAMPLE;
                ST_SAMPLE:  state_d = ST_RECOVER;
                ST_RECOVER: if (tick_done) state_d = (vote_q == VOTE_LAST) ? ST_DONE : ST_LAUNCH;
                ST_DONE:    if (bus.i_ready && valid_q) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Handshake outputs are registered from the next state, so ena=0 drops them.
    always_comb begin
        accept   = ena && (state_q == ST_IDLE) && bus.i_valid && ready_q;
        launch   = ena && (state_q == ST_LAUNCH);
        sample   = ena && (state_q == ST_SAMPLE);
        run_tick = ena && ((state_q == ST_SETTLE) || (state_q == ST_RECOVER));
        ready_d  = ena && (state_d == ST_IDLE);
        valid_d  = ena && (state_d == ST_DONE);
    end

    always_comb begin
        chal_d  = accept ? bus.i_challenge : chal_q;
        pulse_d = launch ? 1'b1 : (sample ? 1'b0 : pulse_q);
        tick_d  = tick_q;
        if (run_tick) tick_d = tick_done ? '0 : tick_q + 1'b1;
        vote_d  = vote_q;
        if (accept) vote_d = '0;
        else if (ena && (state_q == ST_RECOVER) && tick_done && (vote_q != VOTE_LAST))
            vote_d = vote_q + 1'b1;
        resp_d  = (state_d == ST_DONE) ? maj_w  : resp_q;
        unst_d  = (state_d == ST_DONE) ? diff_w : unst_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            tick_q  <= '0;
            vote_q  <= '0;
            chal_q  <= '0;
            resp_q  <= '0;
            unst_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            ready_q <= ready_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            tick_q  <= tick_d;
            vote_q  <= vote_d;
            chal_q  <= chal_d;
            resp_q  <= resp_d;
            unst_q  <= unst_d;
            sync1_q <= arb_bus_w;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < N_CHAINS; gi++) begin : gen_chain
        logic [C_LENGTH-1:0] rot_w;
        logic                arb_w;
        logic [CW-1:0]       count_q, count_d;

        // Chain gi sees the challenge rotated left by gi bits.
        assign rot_w = C_LENGTH'({chal_q, chal_q} >> (C_LENGTH - (gi % C_LENGTH)));

        (* dont_touch = "true" *)
        puf_delay_chain #(.C_LENGTH(C_LENGTH)) u_chain (
            .challenge_i (rot_w),
            .pulse_i     (pulse_q),
            .arb_o       (arb_w)
        );
        assign arb_bus_w[gi] = arb_w;

        assign count_d = accept ? '0 : (sample ? count_q + CW'(sync2_q[gi]) : count_q);
        always_ff @(posedge clk) begin
            if (!rst_n) count_q <= '0;
            else        count_q <= count_d;
        end
        assign maj_w[gi] = (count_q > VOTE_HALF);

`ifdef PUF_STABILITY_EN
        logic first_q, first_d, diff_q, diff_d;
        always_comb begin
            first_d = first_q;
            diff_d  = diff_q;
            if (accept) diff_d = 1'b0;
            else if (sample) begin
                if (vote_q == '0)                  first_d = sync2_q[gi];
                else if (sync2_q[gi] != first_q)   diff_d  = 1'b1;
            end
        end
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                first_q <= 1'b0;
                diff_q  <= 1'b0;
            end else begin
                first_q <= first_d;
                diff_q  <= diff_d;
            end
        end
        assign diff_w[gi] = diff_q;
`else
        assign diff_w[gi] = 1'b0;
`endif
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_response = resp_q;
    assign bus.o_unstable = unst_q;
endmodule

// File: tb/tb_puf_response_engine.sv
// Directed bench for puf_response_engine with a response scoreboard.
module tb_puf_response_engine;

    typedef struct {
        logic [7:0] chal;
        logic [3:0] resp;
        logic [3:0] unst;
    } exp_t;

    exp_t exp_q[$];
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    puf_response_engine_if #(.C_LENGTH(8), .N_CHAINS(4)) bus ();

    puf_response_engine #(
        .C_LENGTH(8), .N_CHAINS(4), .N_VOTES(5), .SETTLE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: chain k parity of (challenge rotl k) & A5.
    function automatic logic [3:0] model_resp(input logic [7:0] ch);
        logic [7:0] m;
        logic [7:0] r;
        logic [3:0] res;
        m = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            r = (ch << k) | (ch >> (8 - k));
            res[k] = ^(r & m);
        end
        return res;
    endfunction

    // Returns in cycle 1 (accept cycle is cycle 0).
    task automatic send(input logic [7:0] ch, input logic [3:0] unst_exp);
        int   n;
        exp_t e;
        n = 0;
        bus.i_valid     = 1'b1;
        bus.i_challenge = ch;
        while (bus.o_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("accept_ready", bus.o_ready, 1);
        step();
        bus.i_valid = 1'b0;
        e.chal = ch;
        e.resp = model_resp(ch);
        e.unst = unst_exp;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string tag, input int start, input int exp_cyc);
        int n;
        n = start;
        while (bus.o_valid !== 1'b1 && n < exp_cyc + 100) begin
            step();
            n++;
        end
        check(tag, n, exp_cyc);
    endtask

    task automatic receive(input string tag, input int hold);
        exp_t e;
        check({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({tag, "_valid"}, bus.o_valid, 1);
        check({tag, "_resp"}, bus.o_response, e.resp);
        check({tag, "_unst"}, bus.o_unstable, e.unst);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_resp"}, bus.o_response, e.resp);
            check({tag, "_hold_ready"}, bus.o_ready, 0);
            check({tag, "_hold_valid"}, bus.o_valid, 1);
        end
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        check({tag, "_post_valid"}, bus.o_valid, 0);
        check({tag, "_post_ready"}, bus.o_ready, 1);
        $display("txn %s chal=%h resp=%b unst=%b exp_resp=%b exp_unst=%b",
                 tag, e.chal, bus.o_response, bus.o_unstable, e.resp, e.unst);
    endtask

    initial begin
        logic [3:0] unst_stab;
        int         seen;
`ifdef PUF_STABILITY_EN
        unst_stab = 4'b0100;
`else
        unst_stab = 4'b0000;
`endif
        bus.i_valid     = 1'b0;
        bus.i_challenge = 8'h00;
        bus.i_ready     = 1'b0;
        rst_n = 1'b0;
        ena   = 1'b1;

        // Reset held for two cycles, then release.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_valid", bus.o_valid, 0);
            check("rst_resp", bus.o_response, 0);
            check("rst_ready", bus.o_ready, 0);
        end
        rst_n = 1'b1;
        step();
        check("rel_ready", bus.o_ready, 1);
        check("rel_valid", bus.o_valid, 0);

        // Basic response plus 20-cycle output hold.
        send(8'h01, 4'b0000);
        wait_valid("lat_basic", 1, 51);
        receive("basic", 20);

        // Chain 2 arbiter forced low for votes 0 and 1.
        force dut.gen_chain[2].arb_w = 1'b0;
        send(8'h01, unst_stab);
        repeat (19) step();
        release dut.gen_chain[2].arb_w;
        wait_valid("lat_stab", 20, 51);
        receive("stab", 0);

        // Enable freeze for 10 cycles during SETTLE.
        send(8'h96, 4'b0000);
        step();
        step();
        ena = 1'b0;
        repeat (10) step();
        check("freeze_valid", bus.o_valid, 0);
        check("freeze_ready", bus.o_ready, 0);
        ena = 1'b1;
        wait_valid("lat_ena", 13, 61);
        receive("ena", 0);

        // Reset mid-operation at cycle 20.
        send(8'h01, 4'b0000);
        repeat (19) step();
        rst_n = 1'b0;
        step();
        check("midrst_pulse", dut.pulse_q, 0);
        check("midrst_valid", bus.o_valid, 0);
        check("midrst_ready", bus.o_ready, 0);
        step();
        rst_n = 1'b1;
        exp_q.delete();
        step();
        check("midrst_rel_ready", bus.o_ready, 1);

        // 8'hFF with a busy-time challenge that must be ignored.
        send(8'hFF, 4'b0000);
        repeat (4) step();
        bus.i_valid     = 1'b1;
        bus.i_challenge = 8'h01;
        repeat (10) step();
        check("busy_ready", bus.o_ready, 0);
        bus.i_valid = 1'b0;
        wait_valid("lat_ff", 15, 51);
        receive("ff", 0);
        seen = 0;
        repeat (70) begin
            step();
            if (bus.o_valid === 1'b1) seen = 1;
        end
        check("busy_not_captured", seen, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
